// File: rtl/doodle_physics_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : doodle_physics_engine_if
// Brief    : Control and position bus between game logic and the physics engine.
// Revision : 1.0
// ============================================================================
interface doodle_physics_engine_if #(
    parameter int COORD_W = 16
) ();
    logic               physicsUpdate;
    logic               left;
    logic               right;
    logic               hasCollide;
    logic               spring;
    logic               restart;
    logic [COORD_W-1:0] doodleX;
    logic [COORD_W-1:0] doodleY;
    logic [1:0]         jumpState;
    logic               gameOver;
    logic [15:0]        landCount;

    modport master (
        output physicsUpdate, left, right, hasCollide, spring, restart,
        input  doodleX, doodleY, jumpState, gameOver, landCount
    );

    modport slave (
        input  physicsUpdate, left, right, hasCollide, spring, restart,
        output doodleX, doodleY, jumpState, gameOver, landCount
    );
endinterface
`default_nettype wire

// File: rtl/doodle_physics_engine.sv
`default_nettype none
// ============================================================================
// Module   : doodle_physics_engine
// Brief    : Tick-driven doodle jump physics: rise/fall/landing, X wrap-around.
//            Optional spring jumps when DOODLE_SPRING_EN is defined.
// Revision : 1.0
// ============================================================================
module doodle_physics_engine #(
    parameter int SCREEN_WIDTH    = 400,
    parameter int SCREEN_HEIGHT   = 700,
    parameter int COORD_W         = 16,
    parameter int MAX_JUMP_HEIGHT = 80,
    parameter int H_STEP          = 2,
    parameter int V_STEP          = 1
) (
    input  wire logic              clk,
    input  wire logic              reset,
    doodle_physics_engine_if.slave bus
);
    typedef logic [COORD_W:0] wide_t;
    typedef enum logic [1:0] {
        RISE      = 2'd0,
        FALL      = 2'd1,
        GAME_OVER = 2'd2
    } state_t;

    localparam logic [COORD_W-1:0] c_x_init = COORD_W'(SCREEN_WIDTH / 2);
    localparam wide_t c_width = wide_t'(SCREEN_WIDTH);
    localparam wide_t c_top   = wide_t'(SCREEN_HEIGHT - 1);
    localparam wide_t c_jump  = wide_t'(MAX_JUMP_HEIGHT);
    localparam wide_t c_h     = wide_t'(H_STEP);
    localparam wide_t c_v     = wide_t'(V_STEP);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d, base_q, base_d;
    logic [15:0]        land_count_q, land_count_d;
    logic               spring_q, spring_d;

    wide_t x_w, y_w, y_up_w, y_dn_w, thr_raw_w, thr_w, x_next_w;

    assign x_w    = {1'b0, x_q};
    assign y_w    = {1'b0, y_q};
    assign y_up_w = y_w + c_v;
    assign y_dn_w = y_w - c_v;

`ifdef DOODLE_SPRING_EN
    assign thr_raw_w = {1'b0, base_q} + (spring_q ? (c_jump << 1) : c_jump);
`else
    // Spring input is accepted on the bus but has no effect in this build.
    logic unused_spring;
    assign unused_spring = bus.spring ^ spring_q;
    assign thr_raw_w     = {1'b0, base_q} + c_jump;
`endif
    assign thr_w = (thr_raw_w > c_top) ? c_top : thr_raw_w;

    always_comb begin
        x_next_w = x_w;
        if (bus.left && !bus.right) begin
            x_next_w = (x_w < c_h) ? (x_w + c_width - c_h) : (x_w - c_h);
        end else if (bus.right && !bus.left) begin
            x_next_w = ((x_w + c_h) >= c_width) ? (x_w + c_h - c_width) : (x_w + c_h);
        end
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        base_d       = base_q;
        land_count_d = land_count_q;
        spring_d     = spring_q;
        if (state_q == GAME_OVER) begin
            if (bus.restart) begin
                state_d      = RISE;
                x_d          = c_x_init;
                y_d          = '0;
                base_d       = '0;
                land_count_d = '0;
                spring_d     = 1'b0;
            end
        end else if (bus.physicsUpdate) begin
            x_d = x_next_w[COORD_W-1:0];
            if (state_q == RISE) begin
                // Apex tick: hold Y and only turn around.
                if (y_w == thr_w) begin
                    state_d = FALL;
                end else if (y_up_w > thr_w) begin
                    y_d = thr_w[COORD_W-1:0];
                end else begin
                    y_d = y_up_w[COORD_W-1:0];
                end
            end else if (bus.hasCollide) begin
                state_d = RISE;
                base_d  = y_q;
                if (land_count_q != 16'hFFFF) begin
                    land_count_d = land_count_q + 16'd1;
                end
`ifdef DOODLE_SPRING_EN
                spring_d = bus.spring;
`endif
            end else if (y_w < c_v) begin
                y_d     = '0;
                state_d = GAME_OVER;
            end else begin
                y_d = y_dn_w[COORD_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RISE;
            x_q          <= c_x_init;
            y_q          <= '0;
            base_q       <= '0;
            land_count_q <= '0;
            spring_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            base_q       <= base_d;
            land_count_q <= land_count_d;
            spring_q     <= spring_d;
        end
    end

    assign bus.doodleX   = x_q;
    assign bus.doodleY   = y_q;
    assign bus.jumpState = state_q;
    assign bus.gameOver  = (state_q == GAME_OVER);
    assign bus.landCount = land_count_q;
endmodule
`default_nettype wire

// File: tb/tb_doodle_physics_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_doodle_physics_engine
// Brief    : Scoreboard bench for doodle_physics_engine against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_doodle_physics_engine;
    localparam int W   = 400;
    localparam int H   = 700;
    localparam int MJH = 80;
    localparam int HS  = 2;
    localparam int VS  = 1;
`ifdef DOODLE_SPRING_EN
    localparam bit SPRING_EN = 1'b1;
`else
    localparam bit SPRING_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    doodle_physics_engine_if #(.COORD_W(16)) bus ();

    doodle_physics_engine #(
        .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .COORD_W(16),
        .MAX_JUMP_HEIGHT(MJH), .H_STEP(HS), .V_STEP(VS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int st;
        int go;
        int lc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: rules applied directly on integers.
    int m_x, m_y, m_base, m_st, m_lc;
    bit m_spr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_x = W / 2; m_y = 0; m_base = 0; m_st = 0; m_lc = 0; m_spr = 1'b0;
    endtask

    task automatic m_step(input bit pu, input bit l, input bit r,
                          input bit hc, input bit sp, input bit rs);
        int apex;
        if (m_st == 2) begin
            if (rs) m_reset();
            return;
        end
        if (!pu) return;
        apex = m_base + (m_spr ? 2 * MJH : MJH);
        if (apex > H - 1) apex = H - 1;
        if (m_st == 0) begin
            if (m_y == apex) m_st = 1;
            else m_y = (m_y + VS > apex) ? apex : m_y + VS;
        end else if (hc) begin
            m_base = m_y;
            m_st   = 0;
            if (m_lc < 65535) m_lc++;
            m_spr  = SPRING_EN && sp;
        end else if (m_y < VS) begin
            m_y  = 0;
            m_st = 2;
        end else begin
            m_y -= VS;
        end
        if (l && !r)      m_x = (m_x - HS + W) % W;
        else if (r && !l) m_x = (m_x + HS) % W;
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.x = m_x; e.y = m_y; e.st = m_st; e.go = (m_st == 2) ? 1 : 0; e.lc = m_lc;
        return e;
    endfunction

    task automatic tick(input bit pu, input bit l, input bit r,
                        input bit hc, input bit sp, input bit rs);
        @(negedge clk);
        bus.physicsUpdate = pu; bus.left = l; bus.right = r;
        bus.hasCollide = hc; bus.spring = sp; bus.restart = rs;
        m_step(pu, l, r, hc, sp, rs);
        q.push_back(snap());
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.physicsUpdate = 0; bus.left = 0; bus.right = 0;
        bus.hasCollide = 0; bus.spring = 0; bus.restart = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        m_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Reset dropped between edges; outputs must already be at reset values.
    task automatic async_reset_check();
        @(negedge clk);
        idle_inputs();
        #2;
        reset = 1'b0;
        #1;
        chk("async_x",  int'(bus.doodleX), W / 2);
        chk("async_y",  int'(bus.doodleY), 0);
        chk("async_st", int'(bus.jumpState), 0);
        chk("async_go", int'(bus.gameOver), 0);
        chk("async_lc", int'(bus.landCount), 0);
        m_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_until(input int target_y, input int target_st, input int bound,
                             input string name);
        int n = 0;
        while (!((target_y < 0 || m_y == target_y) && (target_st < 0 || m_st == target_st))
               && n < bound) begin
            tick(1, 0, 0, 0, 0, 0);
            n++;
        end
        if (n >= bound) begin
            errors++;
            checks++;
            $display("FAIL %s: bound of %0d ticks expired", name, bound);
        end
    endtask

    // Monitor: every edge with a queued expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("mon_x",  int'(bus.doodleX),   e.x);
                chk("mon_y",  int'(bus.doodleY),   e.y);
                chk("mon_st", int'(bus.jumpState), e.st);
                chk("mon_go", int'(bus.gameOver),  e.go);
                chk("mon_lc", int'(bus.landCount), e.lc);
            end
        end
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        m_reset();
        #1 reset = 1'b0;
        #2;
        chk("rst_x", int'(bus.doodleX), 200);
        chk("rst_y", int'(bus.doodleY), 0);
        chk("rst_st", int'(bus.jumpState), 0);
        chk("rst_lc", int'(bus.landCount), 0);
        @(negedge clk);
        reset = 1'b1;

        // Basic rise / apex / fall
        repeat (80) tick(1, 0, 0, 0, 0, 0);
        chk("rise_y80", int'(bus.doodleY), 80);
        chk("rise_st", int'(bus.jumpState), 0);
        tick(1, 0, 0, 0, 0, 0);
        chk("apex_st", int'(bus.jumpState), 1);
        chk("apex_y", int'(bus.doodleY), 80);
        tick(1, 0, 0, 0, 0, 0);
        chk("fall_y79", int'(bus.doodleY), 79);
        tick(0, 1, 0, 1, 0, 0);
        chk("notick_y", int'(bus.doodleY), 79);

        // Landing at 50
        run_until(50, -1, 100, "fall_to_50");
        tick(1, 0, 0, 1, 0, 0);
        chk("land_y", int'(bus.doodleY), 50);
        chk("land_st", int'(bus.jumpState), 0);
        chk("land_lc", int'(bus.landCount), 1);
        run_until(-1, 1, 200, "rise_to_130");
        chk("apex130", int'(bus.doodleY), 130);

        // X wrap boundaries
        do_reset();
        repeat (100) tick(1, 1, 0, 0, 0, 0);
        chk("x_zero", int'(bus.doodleX), 0);
        tick(1, 1, 0, 0, 0, 0);
        chk("x_wrap_left", int'(bus.doodleX), 398);
        tick(1, 0, 1, 0, 0, 0);
        chk("x_wrap_right", int'(bus.doodleX), 0);
        tick(1, 1, 1, 0, 0, 0);
        chk("x_both", int'(bus.doodleX), 0);

        // Floor and game over
        run_until(-1, 2, 300, "to_game_over");
        chk("go_flag", int'(bus.gameOver), 1);
        chk("go_y", int'(bus.doodleY), 0);
        repeat (3) tick(1, 0, 1, 1, 0, 0);
        chk("go_frozen_x", int'(bus.doodleX), 0);
        chk("go_st", int'(bus.jumpState), 2);
        tick(0, 0, 0, 0, 0, 1);
        chk("restart_x", int'(bus.doodleX), 200);
        chk("restart_y", int'(bus.doodleY), 0);
        chk("restart_st", int'(bus.jumpState), 0);

`ifdef DOODLE_SPRING_EN
        do_reset();
        run_until(-1, 1, 200, "spring_rise");
        run_until(50, -1, 100, "spring_fall_50");
        tick(1, 0, 0, 1, 1, 0);
        run_until(-1, 1, 300, "spring_apex");
        chk("spring_apex", int'(bus.doodleY), 210);
        run_until(100, -1, 200, "spring_fall_100");
        tick(1, 0, 0, 1, 0, 0);
        run_until(-1, 1, 300, "normal_apex");
        chk("normal_apex", int'(bus.doodleY), 180);
`endif

        // Async reset mid-rise
        do_reset();
        repeat (37) tick(1, 0, 0, 0, 0, 0);
        chk("pre_async_y", int'(bus.doodleY), 37);
        async_reset_check();

        // Randomized play
        for (int seg = 0; seg < 6; seg++) begin
            int hc_mod;
            hc_mod = (seg % 2 == 0) ? 8 : 64;
            for (int i = 0; i < 500; i++) begin
                tick($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 1) == 1, $urandom_range(0, hc_mod - 1) == 0,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
            end
        end
        async_reset_check();

        repeat (3) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
